// File: rtl/conv_pkg.sv
// Constants shared between the window feeder and the 9-tap MAC it feeds.
package conv_pkg;

  // Square kernel edge length; the window is KERNEL_SIZE x KERNEL_SIZE taps.
  localparam int KERNEL_SIZE = 32'sd3;

  // Number of window taps presented to the MAC each window.
  localparam int NUM_TAPS = 32'sd9;

endpackage

// File: rtl/line_buffer.sv
// One image row of storage: indexed combinational read, enabled write.
// Contents carry no reset; stale rows are never turned into windows.
module line_buffer #(
  parameter int DATA_WIDTH = 32'sd16,
  parameter int DEPTH      = 32'sd8,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  logic signed [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  assign rd_data = mem_r[addr];

  // Store the incoming value at the addressed column on a write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_feeder.sv
// Turns a raster pixel stream into 3x3 windows for a 9-tap MAC.
// Two line buffers hold the previous rows; a single output register
// stage carries the window, with ready/valid on both sides.
module window_feeder
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32'sd16,
  parameter int IMG_WIDTH  = 32'sd8,
  parameter int IMG_HEIGHT = 32'sd8
) (
  input  logic                         clk,
  input  logic                         arst_in,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DATA_WIDTH-1:0] pix_data,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic signed [DATA_WIDTH-1:0] win0,
  output logic signed [DATA_WIDTH-1:0] win1,
  output logic signed [DATA_WIDTH-1:0] win2,
  output logic signed [DATA_WIDTH-1:0] win3,
  output logic signed [DATA_WIDTH-1:0] win4,
  output logic signed [DATA_WIDTH-1:0] win5,
  output logic signed [DATA_WIDTH-1:0] win6,
  output logic signed [DATA_WIDTH-1:0] win7,
  output logic signed [DATA_WIDTH-1:0] win8,
  output logic                         win_first,
  output logic                         win_last
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 32'sd1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 32'sd1);
  // First column/row at which a full kernel of real pixels exists.
  localparam logic [COL_W-1:0] COL_START = COL_W'(KERNEL_SIZE - 32'sd1);
  localparam logic [ROW_W-1:0] ROW_START = ROW_W'(KERNEL_SIZE - 32'sd1);

  logic [COL_W-1:0] col_r;
  logic [COL_W-1:0] col_nxt_s;
  logic [ROW_W-1:0] row_r;
  logic [ROW_W-1:0] row_nxt_s;

  logic transfer_s;
  logic emit_s;
  logic pix_ready_s;
  logic win_valid_r;
  logic win_valid_nxt_s;
  logic win_first_r;
  logic win_last_r;

  logic signed [DATA_WIDTH-1:0] lb0_rd_s;
  logic signed [DATA_WIDTH-1:0] lb1_rd_s;

  // Taps packed row-major, element 0 = top-left (oldest), element 8 = newest.
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] win_r;

  // A held window blocks the input; accepting it frees the slot the same cycle.
  assign pix_ready_s = ~win_valid_r | win_ready;
  assign transfer_s  = pix_valid & pix_ready_s;
  assign emit_s      = (row_r >= ROW_START) && (col_r >= COL_START);

  // lb0 holds the previous row, lb1 the row before; lb1 takes lb0's old value.
  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) u_lb0 (
    .clk     (clk),
    .wr_en   (transfer_s),
    .addr    (col_r),
    .wr_data (pix_data),
    .rd_data (lb0_rd_s)
  );

  line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH),
    .ADDR_W     (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (transfer_s),
    .addr    (col_r),
    .wr_data (lb0_rd_s),
    .rd_data (lb1_rd_s)
  );

  // Raster position and window-valid next state; everything moves on a transfer only.
  always_comb begin
    col_nxt_s       = col_r;
    row_nxt_s       = row_r;
    win_valid_nxt_s = win_valid_r;
    if (transfer_s) begin
      win_valid_nxt_s = emit_s;
      if (col_r == COL_LAST) begin
        col_nxt_s = {COL_W{1'b0}};
        if (row_r == ROW_LAST) begin
          row_nxt_s = {ROW_W{1'b0}};
        end else begin
          row_nxt_s = row_r + ROW_W'(32'd1);
        end
      end else begin
        col_nxt_s = col_r + COL_W'(32'd1);
        row_nxt_s = row_r;
      end
    end else if (win_ready) begin
      win_valid_nxt_s = 1'b0;
    end else begin
      win_valid_nxt_s = win_valid_r;
    end
  end

  // Counters, window register and frame markers; held while the window is stalled.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      col_r       <= {COL_W{1'b0}};
      row_r       <= {ROW_W{1'b0}};
      win_valid_r <= 1'b0;
      win_first_r <= 1'b0;
      win_last_r  <= 1'b0;
      win_r       <= '0;
    end else begin
      col_r       <= col_nxt_s;
      row_r       <= row_nxt_s;
      win_valid_r <= win_valid_nxt_s;
      if (transfer_s) begin
        win_first_r <= (row_r == ROW_START) && (col_r == COL_START);
        win_last_r  <= (row_r == ROW_LAST) && (col_r == COL_LAST);
        win_r       <= {pix_data, win_r[8], win_r[7],
                        lb0_rd_s, win_r[5], win_r[4],
                        lb1_rd_s, win_r[2], win_r[1]};
      end
    end
  end

  assign pix_ready = pix_ready_s;
  assign win_valid = win_valid_r;
  assign win_first = win_first_r;
  assign win_last  = win_last_r;
  assign win0      = win_r[0];
  assign win1      = win_r[1];
  assign win2      = win_r[2];
  assign win3      = win_r[3];
  assign win4      = win_r[4];
  assign win5      = win_r[5];
  assign win6      = win_r[6];
  assign win7      = win_r[7];
  assign win8      = win_r[8];

endmodule

// File: doc/window_feeder.md
WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel and window-tap width in bits, signed.
REQ-002 Parameter IMG_WIDTH, default 8: pixels per row; legal range 3..256.
REQ-003 Parameter IMG_HEIGHT, default 8: rows per frame; legal range 3..256.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port arst_in, input, 1: asynchronous reset, active-high.
REQ-006 Port pix_valid, input, 1: upstream pixel valid.
REQ-007 Port pix_ready, output, 1: block accepts a pixel this cycle.
REQ-008 Port pix_data, input, DATA_WIDTH: raster-order pixel, row-major, left to right.
REQ-009 Port win_valid, output, 1: window taps valid; feeds the 9-tap MAC input_valid.
REQ-010 Port win_ready, input, 1: downstream accepts the window.
REQ-011 Ports win0..win8, output, DATA_WIDTH each: 3x3 window, row-major; win0 = (r-2,c-2), win8 = (r,c).
REQ-012 Port win_first, output, 1: the window is the first of the frame; drives the MAC accumulate restart.
REQ-013 Port win_last, output, 1: the window is the last of the frame.

Function
REQ-014 A pixel transfer SHALL occur only in a cycle where pix_valid and pix_ready are both 1.
REQ-015 pix_ready SHALL equal (not win_valid) or win_ready; this is a single output register with no bubble on a continuous stream.
REQ-016 A column counter col (0..IMG_WIDTH-1) and a row counter row (0..IMG_HEIGHT-1) SHALL advance on each transfer only.
- col wraps to 0 at IMG_WIDTH-1 and row then increments.
- At row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, both wrap to 0 (frame end).
REQ-017 Two line buffers of IMG_WIDTH entries SHALL hold the previous two rows. On transfer: lb1[col] <= lb0[col], then lb0[col] <= pix_data.
REQ-018 On each transfer, the 3x3 window register SHALL shift left by one column; the new right column is (lb1[col], lb0[col], pix_data), top to bottom.
REQ-019 A transfer with row>=2 and col>=2 SHALL, in the next cycle, set win_valid=1 and present the updated window. Latency is 1 cycle from transfer to win_valid.
REQ-020 A transfer with row<2 or col<2 SHALL produce no window. win_valid clears if the current window is accepted in that cycle.
REQ-021 While win_valid=1 and win_ready=0, win0..win8, win_first and win_last SHALL hold stable; no transfer occurs in that cycle.
REQ-022 Window acceptance and a new transfer in the same cycle SHALL load the new window (or clear win_valid per REQ-020) without a gap.
REQ-023 win_first SHALL be 1 only with the window from transfer (row=2, col=2); win_last only with the window from transfer (row=IMG_HEIGHT-1, col=IMG_WIDTH-1).
REQ-024 Each frame SHALL yield exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows. No padding is applied.
REQ-025 Back-to-back frames SHALL need no idle cycle. Stale line-buffer data is never emitted, because rows 0..1 produce no windows.

Reset
REQ-026 While arst_in=1, the block SHALL immediately drive win_valid=0, win_first=0, win_last=0, win0..win8=0, col=0 and row=0; pix_ready follows as 1.
REQ-027 Line-buffer contents SHALL NOT require reset.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first pixel after release is treated as (row 0, col 0).

Structure
REQ-029 A shared package conv_pkg SHALL hold KERNEL_SIZE=3 and the tap-count constant 9, which are common with the MAC.
REQ-030 One sub-module, line_buffer, SHALL be used, instantiated twice; it is a DATA_WIDTH x IMG_WIDTH register array with index read and write enable.
REQ-031 Counter widths SHALL be $clog2 of IMG_WIDTH and IMG_HEIGHT.

Verification
REQ-032 4x4 frame of pixels 1..16, win_ready=1 -> 4 windows. The first is 1,2,3,5,6,7,9,10,11 with win_first=1; the last is 6,7,8,10,11,12,14,15,16 with win_last=1.
REQ-033 Same frame with win_ready held 0 for 3 cycles after the first window -> pix_ready=0 and the window is held stable for those cycles; all 4 windows are still delivered in order.
REQ-034 Two consecutive 4x4 frames (1..16, then 101..116) with no gap -> 8 windows. The second frame's first window is 101,102,103,105,106,107,109,110,111, with no data from frame 1.
REQ-035 arst_in pulsed after 6 pixels of a frame, then a full 4x4 frame 1..16 -> outputs zero during reset; afterwards exactly 4 correct windows.
REQ-036 Random pix_valid and win_ready (50%) on an 8x8 frame -> 36 windows matching a reference model; no window is lost or duplicated.
